// File: rtl/ex_mem_pipe.sv
// EX/MEM pipeline register with multi-cycle HI/LO feedback and bubble counter.
// Flush kills the held instruction; stalls decode into pass/bubble/hold.
module ex_mem_pipe #(
    parameter int DW  = 32,
    parameter int AW  = 5,
    parameter int OPW = 8,
    parameter int CW  = 2,
    parameter int BW  = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [5:0]    stall,
    input  logic          flush,
    input  logic [AW-1:0] ex_wd,
    input  logic          ex_wreg,
    input  logic [DW-1:0] ex_wdata,
    input  logic          ex_whilo,
    input  logic [DW-1:0] ex_hi,
    input  logic [DW-1:0] ex_lo,
    input  logic [OPW-1:0] ex_aluop,
    input  logic [DW-1:0] ex_mem_addr,
    input  logic [DW-1:0] ex_reg2,
    input  logic [2*DW-1:0] hilo_i,
    input  logic [CW-1:0] cnt_i,
    output logic [AW-1:0] mem_wd,
    output logic          mem_wreg,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_whilo,
    output logic [DW-1:0] mem_hi,
    output logic [DW-1:0] mem_lo,
    output logic [OPW-1:0] mem_aluop,
    output logic [DW-1:0] mem_mem_addr,
    output logic [DW-1:0] mem_reg2,
    output logic [2*DW-1:0] hilo_o,
    output logic [CW-1:0] cnt_o,
    output logic [BW-1:0] bubble_cnt
);

    logic do_pass;
    logic do_bubble;
    logic do_hold;
    logic do_idle;

    // Only EX (bit3) and MEM (bit4) stall bits matter here
    always_comb begin
        do_pass   = !stall[3] && !stall[4];
        do_bubble =  stall[3] && !stall[4];
        do_hold   =  stall[3] &&  stall[4];
        do_idle   = !stall[3] &&  stall[4];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_wd       <= '0;
            mem_wreg     <= 1'b0;
            mem_wdata    <= '0;
            mem_whilo    <= 1'b0;
            mem_hi       <= '0;
            mem_lo       <= '0;
            mem_aluop    <= '0;
            mem_mem_addr <= '0;
            mem_reg2     <= '0;
            hilo_o       <= '0;
            cnt_o        <= '0;
            bubble_cnt   <= '0;
        end else if (flush) begin
            mem_wd       <= '0;
            mem_wreg     <= 1'b0;
            mem_wdata    <= '0;
            mem_whilo    <= 1'b0;
            mem_hi       <= '0;
            mem_lo       <= '0;
            mem_aluop    <= '0;
            mem_mem_addr <= '0;
            mem_reg2     <= '0;
            hilo_o       <= '0;
            cnt_o        <= '0;
        end else begin
            unique case (1'b1)
                do_pass: begin
                    mem_wd       <= ex_wd;
                    mem_wreg     <= ex_wreg;
                    mem_wdata    <= ex_wdata;
                    mem_whilo    <= ex_whilo;
                    mem_hi       <= ex_hi;
                    mem_lo       <= ex_lo;
                    mem_aluop    <= ex_aluop;
                    mem_mem_addr <= ex_mem_addr;
                    mem_reg2     <= ex_reg2;
                    hilo_o       <= '0;
                    cnt_o        <= '0;
                end
                do_bubble: begin
                    mem_wd       <= '0;
                    mem_wreg     <= 1'b0;
                    mem_wdata    <= '0;
                    mem_whilo    <= 1'b0;
                    mem_hi       <= '0;
                    mem_lo       <= '0;
                    mem_aluop    <= '0;
                    mem_mem_addr <= '0;
                    mem_reg2     <= '0;
                    hilo_o       <= hilo_i;
                    cnt_o        <= cnt_i;
                    // Saturate rather than wrap
                    if (bubble_cnt != {BW{1'b1}})
                        bubble_cnt <= bubble_cnt + BW'(1);
                end
                do_hold: begin
                    hilo_o <= hilo_i;
                    cnt_o  <= cnt_i;
                end
                do_idle: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Scoreboard bench for ex_mem_pipe: random + directed stimulus, queue-based checking.
// A second instance with BW=2 exercises bubble counter saturation.
module tb_ex_mem_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic [4:0]  ex_wd;
    logic        ex_wreg;
    logic [31:0] ex_wdata;
    logic        ex_whilo;
    logic [31:0] ex_hi;
    logic [31:0] ex_lo;
    logic [7:0]  ex_aluop;
    logic [31:0] ex_mem_addr;
    logic [31:0] ex_reg2;
    logic [63:0] hilo_i;
    logic [1:0]  cnt_i;

    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [31:0] mem_wdata;
    logic        mem_whilo;
    logic [31:0] mem_hi;
    logic [31:0] mem_lo;
    logic [7:0]  mem_aluop;
    logic [31:0] mem_mem_addr;
    logic [31:0] mem_reg2;
    logic [63:0] hilo_o;
    logic [1:0]  cnt_o;
    logic [15:0] bubble_cnt;

    logic [4:0]  s_wd;
    logic        s_wreg;
    logic [31:0] s_wdata;
    logic        s_whilo;
    logic [31:0] s_hi;
    logic [31:0] s_lo;
    logic [7:0]  s_aluop;
    logic [31:0] s_addr;
    logic [31:0] s_reg2;
    logic [63:0] s_hilo;
    logic [1:0]  s_cnt;
    logic [1:0]  s_bcnt;

    ex_mem_pipe dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
        .ex_whilo(ex_whilo), .ex_hi(ex_hi), .ex_lo(ex_lo),
        .ex_aluop(ex_aluop), .ex_mem_addr(ex_mem_addr), .ex_reg2(ex_reg2),
        .hilo_i(hilo_i), .cnt_i(cnt_i),
        .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
        .mem_whilo(mem_whilo), .mem_hi(mem_hi), .mem_lo(mem_lo),
        .mem_aluop(mem_aluop), .mem_mem_addr(mem_mem_addr),
        .mem_reg2(mem_reg2), .hilo_o(hilo_o), .cnt_o(cnt_o),
        .bubble_cnt(bubble_cnt)
    );

    ex_mem_pipe #(.BW(2)) dut2 (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
        .ex_whilo(ex_whilo), .ex_hi(ex_hi), .ex_lo(ex_lo),
        .ex_aluop(ex_aluop), .ex_mem_addr(ex_mem_addr), .ex_reg2(ex_reg2),
        .hilo_i(hilo_i), .cnt_i(cnt_i),
        .mem_wd(s_wd), .mem_wreg(s_wreg), .mem_wdata(s_wdata),
        .mem_whilo(s_whilo), .mem_hi(s_hi), .mem_lo(s_lo),
        .mem_aluop(s_aluop), .mem_mem_addr(s_addr),
        .mem_reg2(s_reg2), .hilo_o(s_hilo), .cnt_o(s_cnt),
        .bubble_cnt(s_bcnt)
    );

    typedef struct {
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        logic        whilo;
        logic [31:0] hi;
        logic [31:0] lo;
        logic [7:0]  aluop;
        logic [31:0] addr;
        logic [31:0] reg2;
        logic [63:0] hilo;
        logic [1:0]  cnt;
        int          bcnt;
        int          bcnt2;
    } st_t;

    st_t model;
    st_t q[$];
    int  checks = 0;
    int  errors = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic st_t clear_mem(st_t s);
        st_t n = s;
        n.wd = '0; n.wreg = 1'b0; n.wdata = '0; n.whilo = 1'b0;
        n.hi = '0; n.lo = '0; n.aluop = '0; n.addr = '0; n.reg2 = '0;
        return n;
    endfunction

    // Reference: next visible state from current inputs
    task automatic push();
        st_t n = model;
        if (rst) begin
            n = clear_mem(n);
            n.hilo = '0; n.cnt = '0; n.bcnt = 0; n.bcnt2 = 0;
        end else if (flush) begin
            n = clear_mem(n);
            n.hilo = '0; n.cnt = '0;
        end else if (!stall[3] && !stall[4]) begin
            n.wd = ex_wd; n.wreg = ex_wreg; n.wdata = ex_wdata;
            n.whilo = ex_whilo; n.hi = ex_hi; n.lo = ex_lo;
            n.aluop = ex_aluop; n.addr = ex_mem_addr; n.reg2 = ex_reg2;
            n.hilo = '0; n.cnt = '0;
        end else if (stall[3] && !stall[4]) begin
            n = clear_mem(n);
            n.hilo = hilo_i; n.cnt = cnt_i;
            n.bcnt  = (n.bcnt  < 65535) ? n.bcnt + 1  : n.bcnt;
            n.bcnt2 = (n.bcnt2 < 3)     ? n.bcnt2 + 1 : n.bcnt2;
        end else if (stall[3] && stall[4]) begin
            n.hilo = hilo_i; n.cnt = cnt_i;
        end
        model = n;
        q.push_back(n);
    endtask

    task automatic rnd_ex();
        ex_wd       = 5'($urandom);
        ex_wreg     = 1'($urandom);
        ex_wdata    = $urandom;
        ex_whilo    = 1'($urandom);
        ex_hi       = $urandom;
        ex_lo       = $urandom;
        ex_aluop    = 8'($urandom);
        ex_mem_addr = $urandom;
        ex_reg2     = $urandom;
        hilo_i      = {$urandom, $urandom};
        cnt_i       = 2'($urandom);
    endtask

    task automatic cyc(bit r, bit f, logic [5:0] s);
        @(negedge clk);
        rnd_ex();
        rst   = r;
        flush = f;
        stall = s;
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // Monitor: outputs are presented every cycle
    initial begin
        st_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("mem_wd", 64'(mem_wd), 64'(e.wd));
                chk("mem_wreg", 64'(mem_wreg), 64'(e.wreg));
                chk("mem_wdata", 64'(mem_wdata), 64'(e.wdata));
                chk("mem_whilo", 64'(mem_whilo), 64'(e.whilo));
                chk("mem_hi", 64'(mem_hi), 64'(e.hi));
                chk("mem_lo", 64'(mem_lo), 64'(e.lo));
                chk("mem_aluop", 64'(mem_aluop), 64'(e.aluop));
                chk("mem_mem_addr", 64'(mem_mem_addr), 64'(e.addr));
                chk("mem_reg2", 64'(mem_reg2), 64'(e.reg2));
                chk("hilo_o", hilo_o, e.hilo);
                chk("cnt_o", 64'(cnt_o), 64'(e.cnt));
                chk("bubble_cnt", 64'(bubble_cnt), 64'(e.bcnt));
                chk("bubble_cnt_bw2", 64'(s_bcnt), 64'(e.bcnt2));
            end
        end
    end

    initial begin
        int b0;
        logic [1:0] sat_seq [5];
        sat_seq[0] = 2'd1; sat_seq[1] = 2'd2; sat_seq[2] = 2'd3;
        sat_seq[3] = 2'd3; sat_seq[4] = 2'd3;
        rst = 1'b1; flush = 1'b0; stall = '0;
        rnd_ex();

        cyc(1, 0, 6'b000000); push();
        settle();
        chk("reset_wd", 64'(mem_wd), 64'd0);
        chk("reset_bcnt", 64'(bubble_cnt), 64'd0);

        // Pass
        cyc(0, 0, 6'b000000);
        ex_wd = 5'd3; ex_wreg = 1'b1; ex_wdata = 32'hDEADBEEF;
        push();
        settle();
        chk("pass_wd", 64'(mem_wd), 64'd3);
        chk("pass_wreg", 64'(mem_wreg), 64'd1);
        chk("pass_wdata", 64'(mem_wdata), 64'hDEADBEEF);
        chk("pass_hilo", hilo_o, 64'd0);

        // Bubble
        cyc(0, 0, 6'b001111);
        ex_wreg = 1'b1; hilo_i = 64'h1234; cnt_i = 2'd1;
        b0 = model.bcnt;
        push();
        settle();
        chk("bub_wreg", 64'(mem_wreg), 64'd0);
        chk("bub_wdata", 64'(mem_wdata), 64'd0);
        chk("bub_hilo", hilo_o, 64'h1234);
        chk("bub_cnt", 64'(cnt_o), 64'd1);
        chk("bub_bcnt", 64'(bubble_cnt), 64'(b0 + 1));

        // Hold
        cyc(0, 0, 6'b000000);
        ex_wdata = 32'hA5A5A5A5;
        push();
        b0 = model.bcnt;
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 6'b011111); push();
            settle();
            chk("hold_wdata", 64'(mem_wdata), 64'hA5A5A5A5);
            chk("hold_bcnt", 64'(bubble_cnt), 64'(b0));
        end

        // Flush beats bubble
        b0 = model.bcnt;
        cyc(0, 1, 6'b001111);
        hilo_i = 64'h55;
        push();
        settle();
        chk("flush_wdata", 64'(mem_wdata), 64'd0);
        chk("flush_wd", 64'(mem_wd), 64'd0);
        chk("flush_hilo", hilo_o, 64'd0);
        chk("flush_cnt", 64'(cnt_o), 64'd0);
        chk("flush_bcnt", 64'(bubble_cnt), 64'(b0));

        // Saturation on BW=2 instance
        cyc(1, 0, 6'b000000); push();
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 6'b001000); push();
            settle();
            chk("sat_bcnt2", 64'(s_bcnt), 64'(sat_seq[i]));
        end

        // Reset mid multi-cycle op
        cyc(0, 0, 6'b001000);
        hilo_i = 64'hCAFE; cnt_i = 2'd1;
        push();
        settle();
        chk("midop_cnt", 64'(cnt_o), 64'd1);
        cyc(1, 0, 6'b011000); push();
        settle();
        chk("midrst_hilo", hilo_o, 64'd0);
        chk("midrst_cnt", 64'(cnt_o), 64'd0);
        chk("midrst_bcnt", 64'(bubble_cnt), 64'd0);
        cyc(0, 0, 6'b000000);
        ex_wd = 5'd9;
        push();
        settle();
        chk("after_rst_wd", 64'(mem_wd), 64'd9);

        // Random traffic, including ignored stall bits and illegal combo
        for (int i = 0; i < 400; i++) begin
            cyc($urandom_range(0, 49) == 0, $urandom_range(0, 9) == 0,
                6'($urandom_range(0, 63)));
            push();
        end

        repeat (3) @(posedge clk);
        #2;
        chk("queue_drained", 64'(q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
